// File: rtl/sprite_motion_ctrl_if.sv
// sprite_motion_ctrl_if: frame-timing, speed/pause controls and sprite state
// outputs exchanged between a controller (master) and the motion block (slave).
interface sprite_motion_ctrl_if;
    logic       vsync;
    logic [3:0] horz_speed;
    logic [3:0] vert_speed;
    logic       pause;
    logic [9:0] obj_x;
    logic [9:0] obj_y;
    logic       horz_dir;
    logic       vert_dir;
    logic [2:0] color_state;
    logic       bounce;

    modport master (
        output vsync, horz_speed, vert_speed, pause,
        input  obj_x, obj_y, horz_dir, vert_dir, color_state, bounce
    );

    modport slave (
        input  vsync, horz_speed, vert_speed, pause,
        output obj_x, obj_y, horz_dir, vert_dir, color_state, bounce
    );
endinterface

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: moves a rectangular sprite once per frame (rising edge of
// vsync), reflecting it off the screen borders and pulsing bounce on any
// direction flip. Optional border-colour cycling is enabled by defining the
// macro SPRITE_MOTION_COLOR_CYCLE_EN; without it color_state is constant 0.
module sprite_motion_ctrl #(
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int OBJ_W          = 50,
    parameter int OBJ_H          = 50,
    parameter int COLOR_INTERVAL = 16
) (
    input logic               clk,
    input logic               rst_n,
    sprite_motion_ctrl_if.slave bus
);

    localparam logic [10:0] SCR_W_L = 11'(SCREEN_W);
    localparam logic [10:0] SCR_H_L = 11'(SCREEN_H);
    localparam logic [10:0] OBJ_W_L = 11'(OBJ_W);
    localparam logic [10:0] OBJ_H_L = 11'(OBJ_H);

    // The frame counter is 4 bits wide, so the interval must fit in 1..16.
    if (COLOR_INTERVAL < 1 || COLOR_INTERVAL > 16) begin : g_bad_interval
        $error("COLOR_INTERVAL must be in 1..16");
    end

    // Result of advancing one axis by one frame.
    typedef struct packed {
        logic [9:0] pos;
        logic       dir;
        logic       flip;
    } axis_step_t;

    // One-axis motion rule: dir=0 moves toward the far border, dir=1 toward 0.
    // A move that would cross a border is refused; the axis holds and reverses.
    function automatic axis_step_t step_axis(
        input logic [9:0]  pos,
        input logic        dir,
        input logic [3:0]  spd,
        input logic [10:0] size,
        input logic [10:0] limit
    );
        axis_step_t r;
        r.pos  = pos;
        r.dir  = dir;
        r.flip = 1'b0;
        if (spd != 4'd0) begin
            if (!dir) begin
                if (({1'b0, pos} + size + {7'd0, spd}) <= limit)
                    r.pos = pos + {6'd0, spd};
                else begin
                    r.dir  = 1'b1;
                    r.flip = 1'b1;
                end
            end else begin
                if (pos >= {6'd0, spd})
                    r.pos = pos - {6'd0, spd};
                else begin
                    r.dir  = 1'b0;
                    r.flip = 1'b1;
                end
            end
        end
        return r;
    endfunction

    logic       vsync_q;
    logic       frame_tick;
    logic       update;
    logic [9:0] obj_x_q;
    logic [9:0] obj_y_q;
    logic       horz_dir_q;
    logic       vert_dir_q;
    logic       bounce_q;
    axis_step_t x_nxt;
    axis_step_t y_nxt;

    assign frame_tick = bus.vsync & ~vsync_q;
    assign update     = frame_tick & ~bus.pause;

    // vsync history for edge detection; resets high so a vsync already high
    // at reset release is not mistaken for a new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vsync_q <= 1'b1;
        else        vsync_q <= bus.vsync;
    end

    // Candidate next position/direction of both axes for this frame.
    always_comb begin
        x_nxt = step_axis(obj_x_q, horz_dir_q, bus.horz_speed, OBJ_W_L, SCR_W_L);
        y_nxt = step_axis(obj_y_q, vert_dir_q, bus.vert_speed, OBJ_H_L, SCR_H_L);
    end

    // Motion state: commit both axes on an update edge; bounce is a one-cycle
    // pulse following any flip, otherwise cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obj_x_q    <= 10'd0;
            obj_y_q    <= 10'd0;
            horz_dir_q <= 1'b0;
            vert_dir_q <= 1'b0;
            bounce_q   <= 1'b0;
        end else begin
            bounce_q <= 1'b0;
            if (update) begin
                obj_x_q    <= x_nxt.pos;
                obj_y_q    <= y_nxt.pos;
                horz_dir_q <= x_nxt.dir;
                vert_dir_q <= y_nxt.dir;
                bounce_q   <= x_nxt.flip | y_nxt.flip;
            end
        end
    end

`ifdef SPRITE_MOTION_COLOR_CYCLE_EN
    localparam logic [3:0] CI_LAST = 4'(COLOR_INTERVAL - 1);

    logic [3:0] frame_cnt;
    logic [2:0] color_q;

    // Colour cycling: count update edges and step the colour index (mod 8)
    // once every COLOR_INTERVAL frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 4'd0;
            color_q   <= 3'd0;
        end else if (update) begin
            if (frame_cnt == CI_LAST) begin
                frame_cnt <= 4'd0;
                color_q   <= color_q + 3'd1;
            end else begin
                frame_cnt <= frame_cnt + 4'd1;
            end
        end
    end

    assign bus.color_state = color_q;
`else
    assign bus.color_state = 3'd0;
`endif

    assign bus.obj_x    = obj_x_q;
    assign bus.obj_y    = obj_y_q;
    assign bus.horz_dir = horz_dir_q;
    assign bus.vert_dir = vert_dir_q;
    assign bus.bounce   = bounce_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: directed scenarios plus randomized frames for
// sprite_motion_ctrl, compared against a frame-level behavioural model.
module tb_sprite_motion_ctrl;

    localparam int SW = 640;
    localparam int SH = 480;
    localparam int OW = 50;
    localparam int OH = 50;
    localparam int CI = 16;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    sprite_motion_ctrl_if bus ();

    sprite_motion_ctrl #(
        .SCREEN_W(SW), .SCREEN_H(SH), .OBJ_W(OW), .OBJ_H(OH), .COLOR_INTERVAL(CI)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, tracked per frame.
    int m_x, m_y, m_hd, m_vd, m_frames, m_flip;

    function automatic int m_color();
`ifdef SPRITE_MOTION_COLOR_CYCLE_EN
        return (m_frames / CI) % 8;
`else
        return 0;
`endif
    endfunction

    task automatic m_reset();
        m_x = 0; m_y = 0; m_hd = 0; m_vd = 0; m_frames = 0; m_flip = 0;
    endtask

    // Advance the model by one unpaused frame.
    task automatic m_frame(input int hs, input int vs);
        m_flip = 0;
        if (hs != 0) begin
            if (m_hd == 0) begin
                if (m_x + OW + hs <= SW) m_x += hs; else begin m_hd = 1; m_flip = 1; end
            end else begin
                if (m_x >= hs) m_x -= hs; else begin m_hd = 0; m_flip = 1; end
            end
        end
        if (vs != 0) begin
            if (m_vd == 0) begin
                if (m_y + OH + vs <= SH) m_y += vs; else begin m_vd = 1; m_flip = 1; end
            end else begin
                if (m_y >= vs) m_y -= vs; else begin m_vd = 0; m_flip = 1; end
            end
        end
        m_frames++;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".x"},     32'(bus.obj_x),       32'(m_x));
        check({tag, ".y"},     32'(bus.obj_y),       32'(m_y));
        check({tag, ".hdir"},  32'(bus.horz_dir),    32'(m_hd));
        check({tag, ".vdir"},  32'(bus.vert_dir),    32'(m_vd));
        check({tag, ".color"}, 32'(bus.color_state), 32'(m_color()));
    endtask

    // Reset asserted between clock edges; outputs must clear before any edge.
    task automatic do_reset(input logic vsync_level, input bit chk_async);
        @(negedge clk);
        bus.vsync = vsync_level;
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        if (chk_async) begin
            check_state("async_rst");
            check("async_rst.bounce", 32'(bus.bounce), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One vsync pulse: rising edge with the given speeds, then speeds scrambled
    // while vsync stays high and after it falls (neither may cause motion).
    task automatic frame(input int hs, input int vs, input bit p, input string tag);
        @(negedge clk);
        bus.horz_speed = 4'(hs);
        bus.vert_speed = 4'(vs);
        bus.pause      = p;
        bus.vsync      = 1'b1;
        @(negedge clk);
        if (!p) m_frame(hs, vs); else m_flip = 0;
        check_state(tag);
        check({tag, ".bounce"}, 32'(bus.bounce), 32'(m_flip));
        bus.horz_speed = 4'($urandom_range(0, 15));
        bus.vert_speed = 4'($urandom_range(0, 15));
        bus.pause      = 1'b0;
        @(negedge clk);
        check({tag, ".bounce_off"}, 32'(bus.bounce), 32'd0);
        check({tag, ".x_hold"},     32'(bus.obj_x),  32'(m_x));
        bus.vsync = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int hs, vs;
        bit p;
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        bus.vsync = 1'b0;
        bus.horz_speed = 4'd0;
        bus.vert_speed = 4'd0;
        bus.pause = 1'b0;
        do_reset(1'b0, 1'b0);
        @(negedge clk);
        check_state("reset");
        check("reset.bounce", 32'(bus.bounce), 32'd0);

        // Three frames straight down-right.
        for (int i = 0; i < 3; i++) frame(4, 2, 1'b0, "basic");
        check("basic.x12", 32'(bus.obj_x), 32'd12);
        check("basic.y6",  32'(bus.obj_y), 32'd6);

        // Walk to x=588, then a speed-3 step would cross the right border.
        for (int i = 0; i < 144; i++) frame(4, 0, 1'b0, "walk_r");
        check("walk_r.x588", 32'(bus.obj_x), 32'd588);
        frame(3, 0, 1'b0, "right_edge");
        check("right_edge.x", 32'(bus.obj_x), 32'd588);
        check("right_edge.hdir", 32'(bus.horz_dir), 32'd1);
        frame(3, 0, 1'b0, "after_edge");
        check("after_edge.x585", 32'(bus.obj_x), 32'd585);

        // Bring y down to 430 and bounce, then up to 1; bring x left to 2.
        for (int i = 0; i < 53; i++) frame(0, 8, 1'b0, "walk_d");
        frame(0, 1, 1'b0, "bottom_edge");
        check("bottom_edge.y430", 32'(bus.obj_y), 32'd430);
        for (int i = 0; i < 39; i++) frame(0, 11, 1'b0, "walk_u");
        for (int i = 0; i < 53; i++) frame(11, 0, 1'b0, "walk_l");
        check("corner.x2", 32'(bus.obj_x), 32'd2);
        check("corner.y1", 32'(bus.obj_y), 32'd1);
        frame(5, 5, 1'b0, "double_flip");
        check("double_flip.hdir", 32'(bus.horz_dir), 32'd0);
        check("double_flip.vdir", 32'(bus.vert_dir), 32'd0);

        // Paused frames change nothing.
        for (int i = 0; i < 20; i++)
            frame(int'($urandom_range(1, 15)), int'($urandom_range(1, 15)), 1'b1, "pause");
        check("pause.x2", 32'(bus.obj_x), 32'd2);
        check("pause.y1", 32'(bus.obj_y), 32'd1);

        // vsync high through reset release: no frame until the next rise.
        do_reset(1'b1, 1'b1);
        bus.horz_speed = 4'd5;
        bus.vert_speed = 4'd5;
        repeat (4) @(negedge clk);
        check_state("vsync_hi_rst");
        bus.vsync = 1'b0;
        frame(5, 5, 1'b0, "first_after_rst");

        // Colour cycling over 128 frames.
        do_reset(1'b0, 1'b1);
        for (int i = 0; i < 128; i++)
            frame(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0, "color");
        check("color.end0", 32'(bus.color_state), 32'd0);

        // Randomized frames with occasional pause.
        for (int i = 0; i < 400; i++) begin
            hs = int'($urandom_range(0, 15));
            vs = int'($urandom_range(0, 15));
            p  = ($urandom_range(0, 3) == 0);
            frame(hs, vs, p, "rand");
            check("rand.xbound", 32'(int'(bus.obj_x) + OW <= SW), 32'd1);
            check("rand.ybound", 32'(int'(bus.obj_y) + OH <= SH), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
